// File: rtl/seg_display_pkg.sv
// Shared types and constants for the seven-segment display scanner.
package seg_display_pkg;

  // Scan FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  // All segments dark (active-low drive)
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Smallest width able to hold values 0..n-1, never less than one bit
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // All-anodes-off pattern for a display of the given width (up to 8 digits)
  function automatic logic [7:0] an_off(input int digits);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) begin
        r[i] = 1'b1;
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Value/control inputs and pin-side outputs of the display scanner.
interface seg_display_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  lz_blank_en;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [DIGITS-1:0]     an_n;
  logic                  frame_done;

  modport master (
    output enable, load, value, dp_in, lz_blank_en,
    input  seg_n, dp_n, an_n, frame_done
  );

  modport slave (
    input  enable, load, value, dp_in, lz_blank_en,
    output seg_n, dp_n, an_n, frame_done
  );
endinterface

// File: rtl/seg_display_scanner_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module SevenSegDecoder (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  // Glyph lookup for 0-9 and A-F
  always_comb begin
    case (i_nibble)
      4'h0:    o_seg_n = 7'h40;
      4'h1:    o_seg_n = 7'h79;
      4'h2:    o_seg_n = 7'h24;
      4'h3:    o_seg_n = 7'h30;
      4'h4:    o_seg_n = 7'h19;
      4'h5:    o_seg_n = 7'h12;
      4'h6:    o_seg_n = 7'h02;
      4'h7:    o_seg_n = 7'h78;
      4'h8:    o_seg_n = 7'h00;
      4'h9:    o_seg_n = 7'h10;
      4'hA:    o_seg_n = 7'h08;
      4'hB:    o_seg_n = 7'h03;
      4'hC:    o_seg_n = 7'h46;
      4'hD:    o_seg_n = 7'h21;
      4'hE:    o_seg_n = 7'h06;
      4'hF:    o_seg_n = 7'h0E;
      default: o_seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed seven-segment scanner: blank gap per slot, leading-zero
// suppression, and a shadow register so each frame shows one coherent value.
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_display_scanner_if.slave  bus
);

  localparam int                CNT_W     = clog2(PRESCALE);
  localparam int                IDX_W     = clog2(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0]  SLOT_END  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        AN_OFF8   = an_off(DIGITS);
  localparam logic [DIGITS-1:0] AN_OFF    = AN_OFF8[DIGITS-1:0];

  state_e              r_state,      w_state_nxt;
  logic [IDX_W-1:0]    r_idx,        w_idx_nxt;
  logic [CNT_W-1:0]    r_cnt,        w_cnt_nxt;
  logic [4*DIGITS-1:0] r_pend_val,   w_pend_val_nxt;
  logic [DIGITS-1:0]   r_pend_dp,    w_pend_dp_nxt;
  logic                r_pend_valid, w_pend_valid_nxt;
  logic [4*DIGITS-1:0] r_act_val,    w_act_val_nxt;
  logic [DIGITS-1:0]   r_act_dp,     w_act_dp_nxt;
  logic [6:0]          r_seg_n,      w_seg_n_nxt;
  logic                r_dp_n,       w_dp_n_nxt;
  logic [DIGITS-1:0]   r_an_n,       w_an_n_nxt;
  logic                r_frame_done, w_frame_done_nxt;

  logic                w_take;
  logic [4*DIGITS-1:0] w_upper;
  logic                w_suppress;
  logic [6:0]          w_seg_dec;

  // Digits idx and above; the low nibble is the digit being scanned
  assign w_upper    = r_act_val >> {r_idx, 2'b00};
  assign w_suppress = bus.lz_blank_en && (r_idx != IDX_ZERO) && (w_upper == '0);

  SevenSegDecoder u_dec (
    .i_nibble (w_upper[3:0]),
    .o_seg_n  (w_seg_dec)
  );

  // Scan FSM next state and next registered pin values
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_seg_n_nxt      = SEG_OFF;
    w_dp_n_nxt       = 1'b1;
    w_an_n_nxt       = AN_OFF;
    w_frame_done_nxt = 1'b0;
    w_take           = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = IDX_ZERO;
      w_cnt_nxt   = CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = IDX_ZERO;
          w_cnt_nxt   = CNT_ZERO;
          w_take      = 1'b1;
        end
        ST_BLANK: begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (r_cnt == BLANK_END) begin
            w_state_nxt = ST_SHOW;
          end else begin
            w_state_nxt = ST_BLANK;
          end
        end
        ST_SHOW: begin
          if (!w_suppress) begin
            w_seg_n_nxt = w_seg_dec;
            w_dp_n_nxt  = ~r_act_dp[r_idx];
            w_an_n_nxt  = ~({{(DIGITS-1){1'b0}}, 1'b1} << r_idx);
          end else begin
            w_seg_n_nxt = SEG_OFF;
          end
          if (r_cnt == SLOT_END) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = CNT_ZERO;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt        = IDX_ZERO;
              w_frame_done_nxt = 1'b1;
              w_take           = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IDX_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = IDX_ZERO;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // Shadow capture and frame-boundary transfer; a load coinciding with the
  // transfer goes straight to the active copy so nothing is left pending
  always_comb begin
    w_pend_val_nxt   = r_pend_val;
    w_pend_dp_nxt    = r_pend_dp;
    w_pend_valid_nxt = r_pend_valid;
    w_act_val_nxt    = r_act_val;
    w_act_dp_nxt     = r_act_dp;
    if (bus.load) begin
      w_pend_val_nxt   = bus.value;
      w_pend_dp_nxt    = bus.dp_in;
      w_pend_valid_nxt = 1'b1;
    end else begin
      w_pend_valid_nxt = r_pend_valid;
    end
    if (w_take) begin
      if (bus.load) begin
        w_act_val_nxt    = bus.value;
        w_act_dp_nxt     = bus.dp_in;
        w_pend_valid_nxt = 1'b0;
      end else if (r_pend_valid) begin
        w_act_val_nxt    = r_pend_val;
        w_act_dp_nxt     = r_pend_dp;
        w_pend_valid_nxt = 1'b0;
      end else begin
        w_act_val_nxt = r_act_val;
      end
    end else begin
      w_act_val_nxt = r_act_val;
    end
  end

  // State, shadow/active copies and pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= IDX_ZERO;
      r_cnt        <= CNT_ZERO;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_seg_n      <= SEG_OFF;
      r_dp_n       <= 1'b1;
      r_an_n       <= AN_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pend_val   <= w_pend_val_nxt;
      r_pend_dp    <= w_pend_dp_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_act_val    <= w_act_val_nxt;
      r_act_dp     <= w_act_dp_nxt;
      r_seg_n      <= w_seg_n_nxt;
      r_dp_n       <= w_dp_n_nxt;
      r_an_n       <= w_an_n_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.seg_n      = r_seg_n;
  assign bus.dp_n       = r_dp_n;
  assign bus.an_n       = r_an_n;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with DIGITS=4, PRESCALE=4, BLANK=1.
module tb_seg_display_scanner;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int BLANK    = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // one frame of samples packed as {an_n, seg_n, dp_n, frame_done}
  logic [12:0] cap[16];

  seg_display_scanner_if #(.DIGITS(DIGITS)) bus();

  seg_display_scanner #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // at most one anode low on every sampled cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if ($countones(~bus.an_n) > 1) begin
        n_fail++;
        $display("FAIL anode_overlap got an_n=%b required at most one low", bus.an_n);
      end
    end
  end

  function automatic logic [12:0] pins();
    return {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
  endfunction

  // expected sample k of a frame: slot k/4, first cycle of each slot blank
  function automatic logic [12:0] exp_vec(input int k, input logic [3:0] e_an[4],
                                          input logic [6:0] e_seg[4], input logic e_dp[4]);
    int d;
    d = k / 4;
    if ((k % 4) == 0) return {4'hF, 7'h7F, 1'b1, 1'b0};
    return {e_an[d], e_seg[d], e_dp[d], (k == 15) ? 1'b1 : 1'b0};
  endfunction

  task automatic capture_frame();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      cap[k] = pins();
    end
  endtask

  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    bus.value  = v;
    bus.dp_in  = dp;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.load = 1'b0; bus.value = 16'h0000;
    bus.dp_in = 4'h0; bus.lz_blank_en = 1'b0;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (pins() !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL reset_pins got %h required %h", pins(), {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    n_checks++;
    if (dut.r_pend_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_pend_valid got %b required 0", dut.r_pend_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pins() !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL idle_dark got %h required %h", pins(), {4'hF, 7'h7F, 1'b1, 1'b0});
    end
  endtask

  task automatic test_basic();
    logic [3:0] e_an[4];
    logic [6:0] e_seg[4];
    logic       e_dp[4];
    e_an = '{4'hE, 4'hD, 4'hB, 4'h7};
    e_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
    e_dp = '{1'b1, 1'b1, 1'b1, 1'b1};
    pulse_load(16'h12AF, 4'b0000);
    bus.enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.an_n !== 4'hF) begin
      n_fail++; $display("FAIL start_dark got an_n=%h required F", bus.an_n);
    end
    for (int f = 0; f < 2; f++) begin
      capture_frame();
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (cap[k] !== exp_vec(k, e_an, e_seg, e_dp)) begin
          n_fail++; $display("FAIL basic_f%0d[%0d] got %h required %h", f, k, cap[k], exp_vec(k, e_an, e_seg, e_dp));
        end
      end
    end
  endtask

  task automatic test_lz();
    logic [3:0] e_an[4];
    logic [6:0] e_seg[4];
    logic       e_dp[4];
    bit         ok;
    e_dp = '{1'b1, 1'b1, 1'b1, 1'b1};
    bus.lz_blank_en = 1'b1;
    pulse_load(16'h0030, 4'b0000);
    sync_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL lz_sync got timeout required frame_done"); end
    capture_frame();
    e_an = '{4'hE, 4'hD, 4'hF, 4'hF};
    e_seg = '{7'h40, 7'h30, 7'h7F, 7'h7F};
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (cap[k] !== exp_vec(k, e_an, e_seg, e_dp)) begin
        n_fail++; $display("FAIL lz_0030[%0d] got %h required %h", k, cap[k], exp_vec(k, e_an, e_seg, e_dp));
      end
    end
    pulse_load(16'h0000, 4'b0000);
    sync_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL lz_sync2 got timeout required frame_done"); end
    capture_frame();
    e_an = '{4'hE, 4'hF, 4'hF, 4'hF};
    e_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (cap[k] !== exp_vec(k, e_an, e_seg, e_dp)) begin
        n_fail++; $display("FAIL lz_0000[%0d] got %h required %h", k, cap[k], exp_vec(k, e_an, e_seg, e_dp));
      end
    end
  endtask

  task automatic test_tear_free();
    logic [3:0] e_an[4];
    logic [6:0] e_seg[4];
    logic       e_dp[4];
    bit         ok;
    e_an = '{4'hE, 4'hD, 4'hB, 4'h7};
    e_dp = '{1'b1, 1'b1, 1'b1, 1'b1};
    e_seg = '{7'h40, 7'h40, 7'h40, 7'h40};
    bus.lz_blank_en = 1'b0;
    sync_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL tear_sync got timeout required frame_done"); end
    repeat (3) @(negedge clk);
    pulse_load(16'h1111, 4'b0000);
    @(negedge clk);
    pulse_load(16'h2222, 4'b0000);
    for (int k = 6; k < 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (pins() !== exp_vec(k, e_an, e_seg, e_dp)) begin
        n_fail++; $display("FAIL tear_old[%0d] got %h required %h", k, pins(), exp_vec(k, e_an, e_seg, e_dp));
      end
    end
    capture_frame();
    e_seg = '{7'h24, 7'h24, 7'h24, 7'h24};
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (cap[k] !== exp_vec(k, e_an, e_seg, e_dp)) begin
        n_fail++; $display("FAIL tear_new[%0d] got %h required %h", k, cap[k], exp_vec(k, e_an, e_seg, e_dp));
      end
    end
  endtask

  task automatic test_collision();
    logic [3:0] e_an[4];
    logic [6:0] e_seg[4];
    logic       e_dp[4];
    bit         ok;
    e_an = '{4'hE, 4'hD, 4'hB, 4'h7};
    e_dp = '{1'b1, 1'b1, 1'b1, 1'b1};
    e_seg = '{7'h12, 7'h12, 7'h12, 7'h12};
    sync_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL coll_sync got timeout required frame_done"); end
    pulse_load(16'h3333, 4'b0000);
    repeat (14) @(negedge clk);
    bus.value = 16'h5555; bus.dp_in = 4'h0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    n_checks++;
    if (bus.frame_done !== 1'b1) begin
      n_fail++; $display("FAIL coll_fd got %b required 1", bus.frame_done);
    end
    capture_frame();
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (cap[k] !== exp_vec(k, e_an, e_seg, e_dp)) begin
        n_fail++; $display("FAIL coll_frame[%0d] got %h required %h", k, cap[k], exp_vec(k, e_an, e_seg, e_dp));
      end
    end
    n_checks++;
    if (dut.r_pend_valid !== 1'b0) begin
      n_fail++; $display("FAIL coll_pend_valid got %b required 0", dut.r_pend_valid);
    end
  endtask

  task automatic test_disable();
    logic [3:0] e_an[4];
    logic [6:0] e_seg[4];
    logic       e_dp[4];
    bit         ok;
    e_an = '{4'hE, 4'hD, 4'hB, 4'h7};
    e_dp = '{1'b1, 1'b1, 1'b1, 1'b1};
    e_seg = '{7'h12, 7'h12, 7'h12, 7'h12};
    sync_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL dis_sync got timeout required frame_done"); end
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus.an_n !== 4'hB) begin
      n_fail++; $display("FAIL dis_in_digit2 got an_n=%h required B", bus.an_n);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pins() !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL dis_dark got %h required %h", pins(), {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.an_n !== 4'hF) begin
      n_fail++; $display("FAIL dis_restart_dark got an_n=%h required F", bus.an_n);
    end
    capture_frame();
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (cap[k] !== exp_vec(k, e_an, e_seg, e_dp)) begin
        n_fail++; $display("FAIL dis_restart[%0d] got %h required %h", k, cap[k], exp_vec(k, e_an, e_seg, e_dp));
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    sync_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rst_sync got timeout required frame_done"); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.an_n !== 4'hE) begin
      n_fail++; $display("FAIL rst_pre_lit got an_n=%h required E", bus.an_n);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (pins() !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rst_async got %h required %h", pins(), {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    n_checks++;
    if (dut.r_act_val !== 16'h0000) begin
      n_fail++; $display("FAIL rst_active got %h required 0000", dut.r_act_val);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_dp();
    logic [3:0] e_an[4];
    logic [6:0] e_seg[4];
    logic       e_dp[4];
    e_an = '{4'hE, 4'hD, 4'hB, 4'h7};
    e_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    e_dp = '{1'b1, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    pulse_load(16'h1234, 4'b0100);
    bus.enable = 1'b1;
    @(negedge clk);
    capture_frame();
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (cap[k] !== exp_vec(k, e_an, e_seg, e_dp)) begin
        n_fail++; $display("FAIL dp_frame[%0d] got %h required %h", k, cap[k], exp_vec(k, e_an, e_seg, e_dp));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_tear_free();
    test_collision();
    test_disable();
    test_async_reset();
    test_dp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
